// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   state_t     : arbiter state (IDLE, RMW_WR). RMW_WR is only reached when
//                 the design is built with DMEM_ARB_RMW_EN defined.
//   port_idx_t  : 1-bit requester index (0 = m0 / CPU, 1 = m1 / DMA-debug)
//   STRB_FULL   : byte-strobe pattern for a full-word store
//   merge_bytes : per-byte select between a new and an old 32-bit word
package dmem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    typedef logic port_idx_t;

    localparam logic [3:0] STRB_FULL = 4'hF;

    // Bytes whose strobe bit is set come from new_word, the rest keep old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin picker, purely combinational.
//   req[1:0] : request vector (bit i = port i)
//   last_gnt : index of the port granted most recently
//   gnt[1:0] : one-hot grant, all zero when nothing requests
// On contention the port that was not granted last wins.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt == 1'b1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port 4 KB data RAM between m0 (CPU load/store unit) and
// m1 (DMA/debug port) with round-robin arbitration on contention.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   mX_req/we/addr/wdata/wstrb : request and attributes, held until mX_gnt
//   mX_gnt              : combinational accept for this cycle
//   mX_rvalid/mX_rdata  : registered load response, one cycle after grant
//   mem_we/re/addr/wdata: RAM control, driven combinationally from the winner
//   mem_rdata           : RAM combinational read data
// Optional build macro DMEM_ARB_RMW_EN: partial-strobe stores become a
// two-cycle read-modify-write (read + merge, then write in RMW_WR). Without
// it wstrb is ignored and every store is a single-cycle full-word write.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        arb_req;
    logic [1:0]        arb_gnt;
    port_idx_t         last_gnt_q, last_gnt_d;
    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    port_idx_t         sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_RMW_EN
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
    logic [31:0]       rmw_wdata_q, rmw_wdata_d;
    logic [31:0]       rmw_old_q, rmw_old_d;
    logic [3:0]        rmw_strb_q, rmw_strb_d;
    logic [3:0]        sel_strb;

    // No new grants while the write half of a read-modify-write owns the RAM.
    assign arb_req = (state_q == IDLE) ? {m1_req, m0_req} : 2'b00;
`else
    logic              unused_wstrb;

    assign unused_wstrb = ^{m0_wstrb, m1_wstrb};
    assign arb_req      = {m1_req, m0_req};
`endif

    rr_arb2 u_rr_arb2 (
        .req      (arb_req),
        .last_gnt (last_gnt_q),
        .gnt      (arb_gnt)
    );

    // Route the winning port onto the RAM and steer load data back to it.
    always_comb begin
        sel         = arb_gnt[1];
        sel_we      = sel ? m1_we    : m0_we;
        sel_addr    = sel ? m1_addr  : m0_addr;
        sel_wdata   = sel ? m1_wdata : m0_wdata;
        m0_gnt      = arb_gnt[0];
        m1_gnt      = arb_gnt[1];
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        last_gnt_d  = last_gnt_q;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
`ifdef DMEM_ARB_RMW_EN
        sel_strb    = sel ? m1_wstrb : m0_wstrb;
        state_d     = state_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_wdata_d = rmw_wdata_q;
        rmw_old_d   = rmw_old_q;
        rmw_strb_d  = rmw_strb_q;
`endif

        if (arb_gnt != 2'b00) begin
            last_gnt_d = sel;
            mem_addr   = sel_addr;
            if (!sel_we) begin
                mem_re = 1'b1;
                if (sel) begin
                    m1_rvalid_d = 1'b1;
                    m1_rdata_d  = mem_rdata;
                end else begin
                    m0_rvalid_d = 1'b1;
                    m0_rdata_d  = mem_rdata;
                end
            end else begin
`ifdef DMEM_ARB_RMW_EN
                if (sel_strb == STRB_FULL) begin
                    mem_we    = 1'b1;
                    mem_wdata = sel_wdata;
                end else if (sel_strb != 4'h0) begin
                    // Partial store: read the old word now, write the merge next cycle.
                    mem_re      = 1'b1;
                    rmw_old_d   = mem_rdata;
                    rmw_addr_d  = sel_addr;
                    rmw_wdata_d = sel_wdata;
                    rmw_strb_d  = sel_strb;
                    state_d     = RMW_WR;
                end
`else
                mem_we    = 1'b1;
                mem_wdata = sel_wdata;
`endif
            end
        end

`ifdef DMEM_ARB_RMW_EN
        if (state_q == RMW_WR) begin
            mem_we    = 1'b1;
            mem_addr  = rmw_addr_q;
            mem_wdata = merge_bytes(rmw_old_q, rmw_wdata_q, rmw_strb_q);
            state_d   = IDLE;
        end
`endif
    end

    // Reset sends m1 as last winner so m0 takes the first contended cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q  <= 1'b1;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
`ifdef DMEM_ARB_RMW_EN
            state_q     <= IDLE;
            rmw_addr_q  <= '0;
            rmw_wdata_q <= '0;
            rmw_old_q   <= '0;
            rmw_strb_q  <= '0;
`endif
        end else begin
            last_gnt_q  <= last_gnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
`ifdef DMEM_ARB_RMW_EN
            state_q     <= state_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_wdata_q <= rmw_wdata_d;
            rmw_old_q   <= rmw_old_d;
            rmw_strb_q  <= rmw_strb_d;
`endif
        end
    end

    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural 4 KB RAM attached.
// Load responses are predicted into a scoreboard queue when the request is
// driven and retired on the cycle the response is due. Sections that need
// the read-modify-write build are guarded by DMEM_ARB_RMW_EN.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] ram [0:1023];
    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t sb[$];

    always #5 clk = ~clk;

    // Cycle counter used to decide when a predicted load response is due.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: combinational read, write at the rising edge.
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_idx] <= pre_data;
        end else if (mem_we) begin
            ram[mem_addr[11:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = ram[mem_addr[11:2]];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wstrb  (m0_wstrb),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wstrb  (m1_wstrb),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Single comparison point: counts, and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic we0, input logic [31:0] a0,
                                 input logic [31:0] d0, input logic [3:0] s0,
                                 input logic r1, input logic we1, input logic [31:0] a1,
                                 input logic [31:0] d1, input logic [3:0] s1);
        m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0; m0_wstrb = s0;
        m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1; m1_wstrb = s1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic expectLoad(input logic port, input logic [31:0] data);
        sb.push_back('{port: port, data: data, due: cyc + 1});
    endtask

    // Grants for this cycle plus whatever load response the scoreboard expects now.
    task automatic checkCycle(input string tag, input logic eg0, input logic eg1);
        rsp_t r;
        checkOutput({tag, ".m0_gnt"}, {31'h0, m0_gnt}, {31'h0, eg0});
        checkOutput({tag, ".m1_gnt"}, {31'h0, m1_gnt}, {31'h0, eg1});
        if (sb.size() > 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            checkOutput({tag, ".m0_rvalid"}, {31'h0, m0_rvalid}, {31'h0, ~r.port});
            checkOutput({tag, ".m1_rvalid"}, {31'h0, m1_rvalid}, {31'h0, r.port});
            if (r.port) checkOutput({tag, ".m1_rdata"}, m1_rdata, r.data);
            else        checkOutput({tag, ".m0_rdata"}, m0_rdata, r.data);
        end else begin
            checkOutput({tag, ".m0_rvalid"}, {31'h0, m0_rvalid}, 32'h0);
            checkOutput({tag, ".m1_rvalid"}, {31'h0, m1_rvalid}, 32'h0);
        end
    endtask

    task automatic checkMem(input string tag, input logic we, input logic re,
                            input logic [31:0] addr, input logic [31:0] wdata);
        checkOutput({tag, ".mem_we"},    {31'h0, mem_we}, {31'h0, we});
        checkOutput({tag, ".mem_re"},    {31'h0, mem_re}, {31'h0, re});
        checkOutput({tag, ".mem_addr"},  mem_addr, addr);
        checkOutput({tag, ".mem_wdata"}, mem_wdata, wdata);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        applyIdle();

        // Reset: preload words the tests read, and check the reset state.
        pre_we = 1'b1; pre_idx = 10'(32'h14 >> 2); pre_data = 32'h5555AAAA;
        nextCycle();
        pre_idx = 10'(32'h20 >> 2); pre_data = 32'h0BADF00D;
        nextCycle();
        pre_idx = 10'(32'h30 >> 2); pre_data = 32'hAABBCCDD;
        @(negedge clk);
        checkCycle("reset", 1'b0, 1'b0);
        checkMem("reset", 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("reset.m0_rdata", m0_rdata, 32'h0);
        checkOutput("reset.m1_rdata", m1_rdata, 32'h0);
        nextCycle();
        pre_we = 1'b0;
        rst    = 1'b0;

        // m0 store then load of the same word.
        applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkCycle("st0", 1'b1, 1'b0);
        checkMem("st0", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expectLoad(1'b0, 32'hDEADBEEF);
        @(negedge clk);
        checkCycle("ld0", 1'b1, 1'b0);
        checkMem("ld0", 1'b0, 1'b1, 32'h10, 32'h0);
        nextCycle();
        applyIdle();
        @(negedge clk);
        checkCycle("ld0rsp", 1'b0, 1'b0);
        checkMem("ld0rsp", 1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();

        // Reset pulse so the contention test starts from m0-first priority.
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;

        // Both ports load continuously for 4 cycles: m0, m1, m0, m1.
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            expectLoad(i[0], i[0] ? 32'h5555AAAA : 32'hDEADBEEF);
            @(negedge clk);
            checkCycle($sformatf("rr%0d", i), ~i[0], i[0]);
            nextCycle();
        end
        applyIdle();
        @(negedge clk);
        checkCycle("rr_tail", 1'b0, 1'b0);
        nextCycle();

        // m1 store and m0 load to 0x20 together, m1 last granted: m0 sees old data.
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b1, 1'b1, 32'h20, 32'h11223344, 4'hF);
        expectLoad(1'b0, 32'h0BADF00D);
        @(negedge clk);
        checkCycle("raw0", 1'b1, 1'b0);
        checkMem("raw0", 1'b0, 1'b1, 32'h20, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h20, 32'h11223344, 4'hF);
        @(negedge clk);
        checkCycle("raw1", 1'b0, 1'b1);
        checkMem("raw1", 1'b1, 1'b0, 32'h20, 32'h11223344);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expectLoad(1'b0, 32'h11223344);
        @(negedge clk);
        checkCycle("raw2", 1'b1, 1'b0);
        nextCycle();

        // Three idle cycles: bus quiet and read data held.
        applyIdle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkCycle($sformatf("idle%0d", i), 1'b0, 1'b0);
            checkMem($sformatf("idle%0d", i), 1'b0, 1'b0, 32'h0, 32'h0);
            checkOutput($sformatf("idle%0d.m0_hold", i), m0_rdata, 32'h11223344);
            checkOutput($sformatf("idle%0d.m1_hold", i), m1_rdata, 32'h5555AAAA);
            nextCycle();
        end

`ifdef DMEM_ARB_RMW_EN
        // Partial store by m1 becomes read + merged write; m0 waits through RMW_WR.
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h30, 32'h11223344, 4'b0101);
        @(negedge clk);
        checkCycle("rmw_rd", 1'b0, 1'b1);
        checkMem("rmw_rd", 1'b0, 1'b1, 32'h30, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkCycle("rmw_wr", 1'b0, 1'b0);
        checkMem("rmw_wr", 1'b1, 1'b0, 32'h30, 32'hAA22CC44);
        nextCycle();
        expectLoad(1'b0, 32'hAA22CC44);
        @(negedge clk);
        checkCycle("rmw_ld", 1'b1, 1'b0);
        nextCycle();

        // Zero strobe: accepted with no RAM access.
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0);
        @(negedge clk);
        checkCycle("strb0", 1'b0, 1'b1);
        checkMem("strb0", 1'b0, 1'b0, 32'h30, 32'h0);
        nextCycle();

        // Reset during RMW_WR abandons the write.
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h30, 32'h00000000, 4'b0011);
        @(negedge clk);
        checkCycle("rmwrst_rd", 1'b0, 1'b1);
        nextCycle();
        applyIdle();
        rst = 1'b1;
        @(negedge clk);
        checkCycle("rmwrst_wr", 1'b0, 1'b0);
        checkMem("rmwrst_wr", 1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expectLoad(1'b0, 32'hAA22CC44);
        @(negedge clk);
        checkCycle("rmwrst_ld", 1'b1, 1'b0);
        nextCycle();
        applyIdle();
        @(negedge clk);
        checkCycle("rmwrst_rsp", 1'b0, 1'b0);
        nextCycle();
`endif

        // Reset while a load response is pending drops rvalid and clears rdata.
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
        @(negedge clk);
        checkCycle("rstld", 1'b0, 1'b1);
        nextCycle();
        applyIdle();
        rst = 1'b1;
        #1;
        checkOutput("rstld.m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
        checkOutput("rstld.m1_rdata", m1_rdata, 32'h0);
        sb.delete();
        nextCycle();
        rst = 1'b0;
        nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
